// File: rtl/victim_cache_ctrl.sv
// Sequencing controller for an 8-entry fully associative victim cache.
// Handles one L1 miss at a time: tag lookup, optional dirty write-back,
// tag/data update (insert, swap or hand-back to L1) and a response pulse.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_FLUSH  | invalidate every tag entry, one way per cycle, after reset
// S_IDLE   | ready for a new L1 miss request
// S_LOOKUP | tag compare result sampled, target way chosen
// S_WB     | write-back of the dirty replacement victim to memory
// S_UPDATE | tag/data array writes for swap, hand-back or insert
// S_RESP   | one-cycle response, hit/miss statistics updated
module victim_cache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 28,
  parameter int WAYS   = 8,
  parameter int WAY_W  = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_evict_valid_i,
  input  logic [TAG_W-1:0]  req_evict_tag_i,
  input  logic              req_evict_dirty_i,
  output logic              resp_valid_o,
  output logic              resp_hit_o,
  output logic [WAY_W-1:0]  resp_way_o,
  output logic [TAG_W-1:0]  tag_lookup_addr_o,
  input  logic              tag_hit_i,
  input  logic [WAY_W-1:0]  tag_hit_way_i,
  input  logic [TAG_W-1:0]  tag_rd_tag_i,
  input  logic              tag_rd_dirty_i,
  output logic              tag_we_o,
  output logic [WAY_W-1:0]  tag_way_o,
  output logic [TAG_W-1:0]  tag_wr_tag_o,
  output logic              tag_wr_valid_o,
  output logic              tag_wr_dirty_o,
  output logic              data_we_o,
  output logic              data_rd_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [TAG_W-1:0]  wb_tag_o,
  output logic [15:0]       hit_cnt_o,
  output logic [15:0]       miss_cnt_o
);

  localparam logic [2:0] S_FLUSH  = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_LOOKUP = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [WAY_W-1:0] flush_ptr_q, flush_ptr_d;
  logic [WAY_W-1:0] repl_ptr_q, repl_ptr_d;
  logic [WAY_W-1:0] target_q, target_d;
  logic [WAYS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0] req_tag_q, req_tag_d;
  logic [TAG_W-1:0] ev_tag_q, ev_tag_d;
  logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
  logic             ev_valid_q, ev_valid_d;
  logic             ev_dirty_q, ev_dirty_d;
  logic             hit_q, hit_d;
  logic             use_repl_q, use_repl_d;
  logic [15:0]      hit_cnt_q, hit_cnt_d;
  logic [15:0]      miss_cnt_q, miss_cnt_d;

  logic             lk_hit;
  logic             all_valid;
  logic [WAY_W-1:0] free_way;
  logic [WAY_W-1:0] lk_way;

  // Lowest-index invalid way; only meaningful while some entry is free.
  always_comb begin
    free_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_way = WAY_W'(i);
    end
  end

  // The shadow valid bit qualifies the array's hit so stale entries never hit.
  assign lk_hit    = tag_hit_i & valid_q[tag_hit_way_i];
  assign all_valid = &valid_q;
  assign lk_way    = lk_hit ? tag_hit_way_i : (all_valid ? repl_ptr_q : free_way);

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

  // Next-state and output decode for the request sequencer.
  always_comb begin
    state_d     = state_q;
    flush_ptr_d = flush_ptr_q;
    repl_ptr_d  = repl_ptr_q;
    target_d    = target_q;
    valid_d     = valid_q;
    req_tag_d   = req_tag_q;
    ev_tag_d    = ev_tag_q;
    wb_tag_d    = wb_tag_q;
    ev_valid_d  = ev_valid_q;
    ev_dirty_d  = ev_dirty_q;
    hit_d       = hit_q;
    use_repl_d  = use_repl_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;

    req_ready_o       = 1'b0;
    resp_valid_o      = 1'b0;
    resp_hit_o        = 1'b0;
    resp_way_o        = '0;
    tag_lookup_addr_o = '0;
    tag_we_o          = 1'b0;
    tag_way_o         = flush_ptr_q;
    tag_wr_tag_o      = '0;
    tag_wr_valid_o    = 1'b0;
    tag_wr_dirty_o    = 1'b0;
    data_we_o         = 1'b0;
    data_rd_o         = 1'b0;
    wb_valid_o        = 1'b0;
    wb_tag_o          = '0;

    case (state_q)
      S_FLUSH: begin
        tag_we_o    = 1'b1;
        flush_ptr_d = flush_ptr_q + 1'b1;
        if (flush_ptr_q == WAY_W'(WAYS - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          req_tag_d  = req_addr_i[ADDR_W-1:4];
          ev_valid_d = req_evict_valid_i;
          ev_tag_d   = req_evict_tag_i;
          ev_dirty_d = req_evict_dirty_i;
          state_d    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        tag_lookup_addr_o = req_tag_q;
        tag_way_o         = lk_way;
        hit_d             = lk_hit;
        target_d          = lk_way;
        use_repl_d        = !lk_hit && all_valid;
        wb_tag_d          = tag_rd_tag_i;
        // Only a full-cache insert displaces a line; it needs a write-back if dirty.
        if (!lk_hit && ev_valid_q && all_valid && tag_rd_dirty_i) state_d = S_WB;
        else                                                     state_d = S_UPDATE;
      end
      S_WB: begin
        wb_valid_o = 1'b1;
        wb_tag_o   = wb_tag_q;
        if (wb_ready_i) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        tag_way_o = target_q;
        if (hit_q) begin
          data_rd_o = 1'b1;
          tag_we_o  = 1'b1;
          if (ev_valid_q) begin
            data_we_o      = 1'b1;
            tag_wr_tag_o   = ev_tag_q;
            tag_wr_valid_o = 1'b1;
            tag_wr_dirty_o = ev_dirty_q;
          end else begin
            // Line moves back to L1; the victim copy is dropped.
            valid_d[target_q] = 1'b0;
          end
        end else if (ev_valid_q) begin
          tag_we_o          = 1'b1;
          data_we_o         = 1'b1;
          tag_wr_tag_o      = ev_tag_q;
          tag_wr_valid_o    = 1'b1;
          tag_wr_dirty_o    = ev_dirty_q;
          valid_d[target_q] = 1'b1;
          if (use_repl_q) begin
            repl_ptr_d = (repl_ptr_q == WAY_W'(WAYS - 1)) ? '0 : repl_ptr_q + 1'b1;
          end
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        resp_hit_o   = hit_q;
        resp_way_o   = target_q;
        if (hit_q) begin
          if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
        end else begin
          if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_FLUSH;
    endcase
  end

  // State registers; reset aborts any operation and restarts the flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_FLUSH;
      flush_ptr_q <= '0;
      repl_ptr_q  <= '0;
      target_q    <= '0;
      valid_q     <= '0;
      req_tag_q   <= '0;
      ev_tag_q    <= '0;
      wb_tag_q    <= '0;
      ev_valid_q  <= 1'b0;
      ev_dirty_q  <= 1'b0;
      hit_q       <= 1'b0;
      use_repl_q  <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      flush_ptr_q <= flush_ptr_d;
      repl_ptr_q  <= repl_ptr_d;
      target_q    <= target_d;
      valid_q     <= valid_d;
      req_tag_q   <= req_tag_d;
      ev_tag_q    <= ev_tag_d;
      wb_tag_q    <= wb_tag_d;
      ev_valid_q  <= ev_valid_d;
      ev_dirty_q  <= ev_dirty_d;
      hit_q       <= hit_d;
      use_repl_q  <= use_repl_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Self-checking bench for victim_cache_ctrl: directed vector table, reset
// and abort sequences, then random requests against a cache-level model.
module tb_victim_cache_ctrl;
  localparam int ADDR_W = 32;
  localparam int TAG_W  = 28;
  localparam int WAYS   = 8;
  localparam int WAY_W  = 3;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i;
  logic              req_evict_valid_i;
  logic [TAG_W-1:0]  req_evict_tag_i;
  logic              req_evict_dirty_i;
  logic              resp_valid_o;
  logic              resp_hit_o;
  logic [WAY_W-1:0]  resp_way_o;
  logic [TAG_W-1:0]  tag_lookup_addr_o;
  logic              tag_hit_i;
  logic [WAY_W-1:0]  tag_hit_way_i;
  logic [TAG_W-1:0]  tag_rd_tag_i;
  logic              tag_rd_dirty_i;
  logic              tag_we_o;
  logic [WAY_W-1:0]  tag_way_o;
  logic [TAG_W-1:0]  tag_wr_tag_o;
  logic              tag_wr_valid_o;
  logic              tag_wr_dirty_o;
  logic              data_we_o;
  logic              data_rd_o;
  logic              wb_valid_o;
  logic              wb_ready_i;
  logic [TAG_W-1:0]  wb_tag_o;
  logic [15:0]       hit_cnt_o;
  logic [15:0]       miss_cnt_o;

  always #5 clk_i = ~clk_i;

  victim_cache_ctrl #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .WAYS(WAYS), .WAY_W(WAY_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_evict_valid_i(req_evict_valid_i), .req_evict_tag_i(req_evict_tag_i),
    .req_evict_dirty_i(req_evict_dirty_i),
    .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o), .resp_way_o(resp_way_o),
    .tag_lookup_addr_o(tag_lookup_addr_o), .tag_hit_i(tag_hit_i), .tag_hit_way_i(tag_hit_way_i),
    .tag_rd_tag_i(tag_rd_tag_i), .tag_rd_dirty_i(tag_rd_dirty_i),
    .tag_we_o(tag_we_o), .tag_way_o(tag_way_o), .tag_wr_tag_o(tag_wr_tag_o),
    .tag_wr_valid_o(tag_wr_valid_o), .tag_wr_dirty_o(tag_wr_dirty_o),
    .data_we_o(data_we_o), .data_rd_o(data_rd_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_tag_o(wb_tag_o),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  // Tag array environment model: written only by the controller.
  logic [TAG_W-1:0] arr_tag   [WAYS];
  logic             arr_val   [WAYS];
  logic             arr_dirty [WAYS];

  always_comb begin
    tag_hit_i     = 1'b0;
    tag_hit_way_i = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (arr_val[i] === 1'b1 && arr_tag[i] == tag_lookup_addr_o) begin
        tag_hit_i     = 1'b1;
        tag_hit_way_i = 3'(i);
      end
    end
  end
  assign tag_rd_tag_i   = arr_tag[tag_way_o];
  assign tag_rd_dirty_i = arr_dirty[tag_way_o];

  always @(posedge clk_i) begin
    if (tag_we_o) begin
      arr_tag[tag_way_o]   <= tag_wr_tag_o;
      arr_val[tag_way_o]   <= tag_wr_valid_o;
      arr_dirty[tag_way_o] <= tag_wr_dirty_o;
    end
  end

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic             ev;
    logic [TAG_W-1:0] evtag;
    logic             evd;
    int               stall;
    logic             hit;
    logic [WAY_W-1:0] way;
    logic             wb;
    logic [TAG_W-1:0] wbtag;
    int               lat;
    logic             twe, dwe, drd, wval;
    logic [TAG_W-1:0] wtag;
  } vec_t;

  typedef struct {
    logic             hit;
    logic [WAY_W-1:0] way;
    int               lat;
    int               wbc;
    logic [TAG_W-1:0] wbtag;
    logic             wbstable;
    int               nwr;
    logic             twe, dwe, drd, wval, wdirty;
    logic [TAG_W-1:0] wtag;
    logic [WAY_W-1:0] uway;
  } obs_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic vec_t mk(input logic [TAG_W-1:0] tag, input logic ev, input logic [TAG_W-1:0] evtag,
                              input logic evd, input int stall, input logic hit, input logic [WAY_W-1:0] way,
                              input logic wb, input logic [TAG_W-1:0] wbtag, input int lat,
                              input logic twe, input logic dwe, input logic drd, input logic wval,
                              input logic [TAG_W-1:0] wtag);
    vec_t v;
    v.tag = tag; v.ev = ev; v.evtag = evtag; v.evd = evd; v.stall = stall;
    v.hit = hit; v.way = way; v.wb = wb; v.wbtag = wbtag; v.lat = lat;
    v.twe = twe; v.dwe = dwe; v.drd = drd; v.wval = wval; v.wtag = wtag;
    return v;
  endfunction

  // Issue one request and observe it through to the response pulse.
  task automatic do_req(input logic [TAG_W-1:0] tag, input logic ev, input logic [TAG_W-1:0] evtag,
                        input logic evd, input int stall, output obs_t r);
    int n;
    int cyc;
    r = '{default: 0};
    r.wbstable = 1'b1;
    n = 0;
    while (!req_ready_o && n < 200) begin tick(); n++; end
    chk("ready_wait", req_ready_o, 1);
    req_valid_i       = 1'b1;
    req_addr_i        = {tag, 4'($urandom)};
    req_evict_valid_i = ev;
    req_evict_tag_i   = evtag;
    req_evict_dirty_i = evd;
    tick();
    req_valid_i       = 1'b0;
    req_evict_tag_i   = TAG_W'($urandom);
    cyc = 1;
    while (!resp_valid_o && cyc < 60) begin
      wb_ready_i = (cyc > stall);
      if (wb_valid_o) begin
        if (r.wbc > 0 && wb_tag_o != r.wbtag) r.wbstable = 1'b0;
        r.wbc++;
        r.wbtag = wb_tag_o;
      end
      if (tag_we_o || data_we_o || data_rd_o) begin
        r.nwr++;
        r.twe = tag_we_o; r.dwe = data_we_o; r.drd = data_rd_o;
        r.wval = tag_wr_valid_o; r.wdirty = tag_wr_dirty_o;
        r.wtag = tag_wr_tag_o; r.uway = tag_way_o;
      end
      tick();
      cyc++;
    end
    chk("resp_seen", resp_valid_o, 1);
    r.lat = cyc;
    r.hit = resp_hit_o;
    r.way = resp_way_o;
    wb_ready_i = 1'b0;
    tick();
    chk("resp_pulse", resp_valid_o, 0);
  endtask

  task automatic check_txn(input string p, input vec_t e, input obs_t r);
    chk({p, ".hit"}, r.hit, e.hit);
    chk({p, ".way"}, r.way, e.way);
    chk({p, ".lat"}, r.lat, e.lat);
    chk({p, ".wb"}, (r.wbc > 0), e.wb);
    if (e.wb) begin
      chk({p, ".wbtag"}, r.wbtag, e.wbtag);
      chk({p, ".wbstable"}, r.wbstable, 1);
    end
    chk({p, ".nwr"}, r.nwr, (e.twe || e.dwe || e.drd) ? 1 : 0);
    chk({p, ".twe"}, r.twe, e.twe);
    chk({p, ".dwe"}, r.dwe, e.dwe);
    chk({p, ".drd"}, r.drd, e.drd);
    if (e.twe || e.dwe || e.drd) chk({p, ".uway"}, r.uway, e.way);
    if (e.twe) chk({p, ".wval"}, r.wval, e.wval);
    if (e.wval) begin
      chk({p, ".wtag"}, r.wtag, e.wtag);
      chk({p, ".wdirty"}, r.wdirty, e.evd);
    end
  endtask

  // Eight flush cycles walking ways 0..7, then ready in IDLE.
  task automatic flush_check(input string p);
    for (int i = 0; i < WAYS; i++) begin
      chk({p, ".fl_we"}, tag_we_o, 1);
      chk({p, ".fl_way"}, tag_way_o, i);
      chk({p, ".fl_wval"}, tag_wr_valid_o, 0);
      chk({p, ".fl_rdy"}, req_ready_o, 0);
      chk({p, ".fl_resp"}, resp_valid_o, 0);
      chk({p, ".fl_wb"}, wb_valid_o, 0);
      tick();
    end
    chk({p, ".rdy_after_flush"}, req_ready_o, 1);
  endtask

  // Cache-level reference model for the random phase.
  logic [TAG_W-1:0] m_tag   [WAYS];
  logic             m_val   [WAYS];
  logic             m_dirty [WAYS];
  int               m_repl, m_hits, m_misses;

  task automatic model_reset();
    for (int i = 0; i < WAYS; i++) begin m_val[i] = 1'b0; m_tag[i] = '0; m_dirty[i] = 1'b0; end
    m_repl = 0; m_hits = 0; m_misses = 0;
  endtask

  task automatic model(input logic [TAG_W-1:0] tag, input logic ev, input logic [TAG_W-1:0] evtag,
                       input logic evd, input int stall, output vec_t e);
    int hw, free, w, nvalid;
    e = mk(tag, ev, evtag, evd, stall, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
    hw = -1; free = -1; nvalid = 0;
    for (int i = 0; i < WAYS; i++) begin
      if (m_val[i]) nvalid++;
      if (m_val[i] && m_tag[i] == tag && hw < 0) hw = i;
      if (!m_val[i] && free < 0) free = i;
    end
    if (hw >= 0) begin
      m_hits++;
      e.hit = 1'b1; e.way = 3'(hw); e.drd = 1'b1; e.twe = 1'b1;
      if (ev) begin
        e.dwe = 1'b1; e.wval = 1'b1; e.wtag = evtag;
        m_tag[hw] = evtag; m_dirty[hw] = evd;
      end else begin
        m_val[hw] = 1'b0;
      end
    end else begin
      m_misses++;
      w = (free >= 0) ? free : m_repl;
      e.way = 3'(w);
      if (ev) begin
        e.wb = (nvalid == WAYS) && m_dirty[w];
        e.wbtag = m_tag[w];
        e.twe = 1'b1; e.dwe = 1'b1; e.wval = 1'b1; e.wtag = evtag;
        m_tag[w] = evtag; m_val[w] = 1'b1; m_dirty[w] = evd;
        if (nvalid == WAYS) m_repl = (m_repl + 1) % WAYS;
      end
    end
    if (e.wb) e.lat = 3 + ((stall > 1) ? stall : 1);
  endtask

  vec_t vt[21];

  initial begin
    obs_t r;
    vec_t e;
    int n;
    logic [TAG_W-1:0] t;
    logic [TAG_W-1:0] et;
    int fresh;
    int evn;

    for (int i = 0; i < 8; i++) begin
      t  = TAG_W'(32'h50 + i);
      et = TAG_W'(32'h100 + i);
      vt[i] = mk(t, 1, et, (i == 0), 0, 0, 3'(i), 0, 0, 3, 1, 1, 0, 1, et);
    end
    vt[8] = mk(28'h103, 1, 28'h200, 0, 0, 1, 3, 0, 0, 3, 1, 1, 1, 1, 28'h200);
    vt[9] = mk(28'h51, 1, 28'h300, 0, 5, 0, 0, 1, 28'h100, 8, 1, 1, 0, 1, 28'h300);
    for (int i = 0; i < 8; i++) begin
      t  = TAG_W'(32'h60 + i);
      et = TAG_W'(32'h400 + i);
      vt[10 + i] = mk(t, 1, et, 1, 0, 0, 3'((i + 1) % 8), 0, 0, 3, 1, 1, 0, 1, et);
    end
    vt[18] = mk(28'h404, 0, 0, 0, 0, 1, 5, 0, 0, 3, 1, 0, 1, 0, 0);
    vt[19] = mk(28'h70, 1, 28'h500, 0, 0, 0, 5, 0, 0, 3, 1, 1, 0, 1, 28'h500);
    vt[20] = mk(28'h71, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0, 0);

    // Reset with a request already pending.
    rst_i = 1'b1; req_valid_i = 1'b1; req_addr_i = 32'h0000_0990;
    req_evict_valid_i = 1'b0; req_evict_tag_i = '0; req_evict_dirty_i = 1'b0; wb_ready_i = 1'b0;
    tick(); tick(); tick();
    rst_i = 1'b0;
    chk("rst.hit_cnt", hit_cnt_o, 0);
    chk("rst.miss_cnt", miss_cnt_o, 0);
    chk("rst.wb_valid", wb_valid_o, 0);
    flush_check("init");
    req_valid_i = 1'b0;
    tick();

    // Directed vector table.
    for (int i = 0; i < 21; i++) begin
      do_req(vt[i].tag, vt[i].ev, vt[i].evtag, vt[i].evd, vt[i].stall, r);
      check_txn($sformatf("v%0d", i), vt[i], r);
    end
    chk("tbl.hit_cnt", hit_cnt_o, 2);
    chk("tbl.miss_cnt", miss_cnt_o, 19);

    // Reset while a write-back is outstanding.
    n = 0;
    while (!req_ready_o && n < 50) begin tick(); n++; end
    req_valid_i = 1'b1; req_addr_i = {28'h72, 4'h0};
    req_evict_valid_i = 1'b1; req_evict_tag_i = 28'h600; req_evict_dirty_i = 1'b0;
    wb_ready_i = 1'b0;
    tick();
    req_valid_i = 1'b0;
    n = 0;
    while (!wb_valid_o && n < 10) begin tick(); n++; end
    chk("abort.wb_seen", wb_valid_o, 1);
    chk("abort.wb_tag", wb_tag_o, 28'h400);
    tick();
    chk("abort.wb_held", wb_valid_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("abort.wb_drop", wb_valid_o, 0);
    chk("abort.resp", resp_valid_o, 0);
    chk("abort.hit_cnt", hit_cnt_o, 0);
    flush_check("abort");

    // Random requests against the cache-level model.
    model_reset();
    fresh = 0; evn = 0;
    for (int k = 0; k < 300; k++) begin
      int st;
      logic ev, evd;
      if ($urandom_range(0, 1) == 1 && $urandom_range(0, 7) < 8) begin
        int w;
        w = $urandom_range(0, WAYS - 1);
        if (m_val[w]) t = m_tag[w];
        else begin t = TAG_W'(32'hA000 + fresh); fresh++; end
      end else begin
        t = TAG_W'(32'hA000 + fresh); fresh++;
      end
      ev  = ($urandom_range(0, 3) != 0);
      evd = 1'($urandom);
      et  = TAG_W'(32'hB000 + evn); evn++;
      st  = $urandom_range(0, 3);
      model(t, ev, et, evd, st, e);
      do_req(t, ev, et, evd, st, r);
      check_txn($sformatf("r%0d", k), e, r);
    end
    chk("rnd.hit_cnt", hit_cnt_o, m_hits);
    chk("rnd.miss_cnt", miss_cnt_o, m_misses);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/victim_cache_ctrl.md
Name: victim_cache_ctrl

Overview:
- Sequencing controller for the 8-entry fully associative victim cache that sits between L1 and memory.
- Accepts one L1-miss request at a time, together with the optional line L1 is evicting.
- Steps the victim tag array through lookup and update, and steers the victim data array swap.
- Selects replacement slots, issues dirty write-backs to memory, and flushes all entries after reset.

Parameters:
- ADDR_W, 32, CPU byte-address width.
- TAG_W, 28, victim tag width (line address bits [ADDR_W-1:4]).
- WAYS, 8, number of victim entries.
- WAY_W, 3, log2(WAYS).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  1  L1 miss request valid.
- req_ready_o  out  1  controller can accept a request; high only in IDLE.
- req_addr_i  in  ADDR_W  missing address.
- req_evict_valid_i  in  1  L1 is also evicting a line.
- req_evict_tag_i  in  TAG_W  tag of the evicted L1 line.
- req_evict_dirty_i  in  1  evicted L1 line is dirty.
- resp_valid_o  out  1  one-cycle response pulse.
- resp_hit_o  out  1  request hit in the victim cache.
- resp_way_o  out  WAY_W  hit way, or way written on a miss insert.
- tag_lookup_addr_o  out  TAG_W  tag presented to the tag array compare.
- tag_hit_i  in  1  tag array hit.
- tag_hit_way_i  in  WAY_W  hit way from the tag array.
- tag_rd_tag_i  in  TAG_W  tag of the entry addressed by tag_way_o.
- tag_rd_dirty_i  in  1  dirty bit of that entry.
- tag_we_o  out  1  tag array write enable.
- tag_way_o  out  WAY_W  way index for read and write.
- tag_wr_tag_o  out  TAG_W  tag to write.
- tag_wr_valid_o  out  1  valid bit to write.
- tag_wr_dirty_o  out  1  dirty bit to write.
- data_we_o  out  1  data array write of the L1 victim line into tag_way_o.
- data_rd_o  out  1  data array read of tag_way_o toward L1 (hit refill).
- wb_valid_o  out  1  write-back request to memory.
- wb_ready_i  in  1  memory accepts the write-back.
- wb_tag_o  out  TAG_W  tag of the line being written back.
- hit_cnt_o  out  16  saturating hit counter.
- miss_cnt_o  out  16  saturating miss counter.

Behaviour:
- States: FLUSH, IDLE, LOOKUP, UPDATE, WB, RESP.
- Reset:
  - State goes to FLUSH; flush_ptr=0, repl_ptr=0, valid_q=0, both counters=0.
  - All outputs low, except that tag_way_o follows flush_ptr.
- FLUSH:
  - Each cycle: tag_we_o=1, tag_way_o=flush_ptr, tag_wr_valid_o=0, tag_wr_dirty_o=0, tag_wr_tag_o=0.
  - flush_ptr increments each cycle; after way WAYS-1 (8 cycles), go to IDLE.
  - req_ready_o=0 throughout.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch the address tag, evict_valid, evict_tag and evict_dirty, then go to LOOKUP.
- LOOKUP (1 cycle):
  - tag_lookup_addr_o = latched tag.
  - Register hit = tag_hit_i & valid_q[tag_hit_way_i], and hit_way = tag_hit_way_i.
  - Choose the target way:
    - On a hit: hit_way.
    - On a miss with any valid_q bit clear: the lowest-index invalid way.
    - On a miss with all valid: repl_ptr.
  - tag_way_o = target way.
  - Go to WB if all of: miss, evict_valid, all entries valid, tag_rd_dirty_i=1. Capture tag_rd_tag_i as wb_tag.
  - Otherwise go to UPDATE.
- WB:
  - wb_valid_o=1, wb_tag_o=wb_tag, held stable until wb_ready_i.
  - The cycle wb_valid_o & wb_ready_i is seen, go to UPDATE.
- UPDATE (1 cycle), tag_way_o = target way:
  - Hit with evict: tag_we_o=1 and data_we_o=data_rd_o=1 (swap). Writes evict_tag, valid=1, evict_dirty.
  - Hit without evict: data_rd_o=1 and tag_we_o=1 with valid=0. valid_q[hit_way] is cleared, because the line moves to L1.
  - Miss with evict: tag_we_o=1 and data_we_o=1 write evict_tag/valid=1/evict_dirty; valid_q[target] is set. If the insert used repl_ptr, repl_ptr increments modulo WAYS (7 wraps to 0).
  - Miss without evict: no writes.
  - In all cases go to RESP.
- RESP (1 cycle):
  - resp_valid_o=1, resp_hit_o=hit, resp_way_o=target way.
  - Increment hit_cnt_o or miss_cnt_o, saturating at 0xFFFF.
  - Go to IDLE.
- Latency, request accept cycle to resp_valid_o:
  - 3 cycles without write-back.
  - 3 + N cycles when memory stalls N cycles in WB.
- Only one request is in flight; a request made while not in IDLE is not accepted and stays pending.
- repl_ptr advances only on a full-cache insert; a hit never moves it.
- Reset asserted in any state, including mid-WB, aborts the operation:
  - wb_valid_o drops the next cycle.
  - No response is issued.
  - FLUSH restarts from way 0.
- valid_q is the controller's shadow of the array's valid bits and is updated only by its own writes.

Test Plan:
- Reset, then hold req_valid_i=1 -> 8 FLUSH cycles with tag_we_o=1 and tag_way_o=0..7, tag_wr_valid_o=0; req_ready_o first rises at cycle 9.
- Empty cache, miss with evict of tags 0x100..0x107 -> inserts go to ways 0..7 in order, resp_hit_o=0 each time, 3-cycle latency, miss_cnt_o=8.
- Full cache, lookup tag 0x103 with evict 0x200 -> resp_hit_o=1, resp_way_o=3, swap cycle with data_we_o=data_rd_o=1 and tag_wr_tag_o=0x200; repl_ptr unchanged; hit_cnt_o=1.
- Full cache, repl_ptr=0, dirty way 0, miss with evict -> wb_valid_o with wb_tag_o=way 0 tag; wb_ready_i held low 5 cycles -> response 8 cycles after accept; repl_ptr=1.
- Eight further full-cache inserts from repl_ptr=1 -> inserts go to ways 1..7 then 0; repl_ptr wraps back to 1.
- Hit without evict on way 5 -> tag write valid=0 to way 5; the next miss with evict inserts into way 5 (lowest invalid), not repl_ptr.
- rst_i asserted during WB -> wb_valid_o low next cycle, no resp_valid_o, FLUSH restarts at way 0.
